// File: rtl/bitonic_stages_1to3_if.sv
// Data bundle for the first three bitonic sort stages.
// There is no valid/ready pair. A new vector is taken on every clock and every
// stage output is a plain registered value that refreshes each cycle.
// master: the driver of in_data, which also observes the stage outputs.
// slave:  the sorting pipeline.
interface bitonic_stages_1to3_if #(
  parameter int INDEX = 32,
  parameter int WIDTH = 5
);
  logic [INDEX*WIDTH-1:0] in_data;
  logic [INDEX*WIDTH-1:0] s1_data;
  logic [INDEX*WIDTH-1:0] s2_data;
  logic [INDEX*WIDTH-1:0] s3_data;

  modport master (output in_data, input s1_data, s2_data, s3_data);
  modport slave  (input in_data, output s1_data, s2_data, s3_data);
endinterface

// File: rtl/bitonic_stages_1to3.sv
// First three stages of a pipelined bitonic sorting network.
// Stage k (k = 1..3) leaves every aligned block of 2^k elements sorted.
// Even blocks are sorted ascending and odd blocks descending, so the blocks of
// each stage form bitonic sequences for the next stage.
// Optional macro SORT_DESC_EN inverts every block direction. In that build,
// block 0 of s3_data is sorted high-to-low.
// Element i is at [i*WIDTH +: WIDTH]. rst is synchronous and active-high.
module bitonic_stages_1to3 #(
  parameter int INDEX = 32,
  parameter int WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  bitonic_stages_1to3_if.slave bus
);

  localparam int N = INDEX * WIDTH;

  logic [N-1:0] s1_d, s1_q;
  logic [N-1:0] s2_d, s2_q;
  logic [N-1:0] s3_d, s3_q;

  // Bitonic merge for block size 2^k. Each pass j does a compare-exchange on
  // pairs (i, i+2^j) where bit j of i is clear. The direction of a pair is
  // taken from the parity of its block of 2^k elements.
  function automatic logic [N-1:0] merge_stage(input logic [N-1:0] v, input int k);
    logic [N-1:0]     r;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             asc;
    int               p;
    r = v;
    for (int j = k - 1; j >= 0; j--) begin
      for (int i = 0; i < INDEX; i++) begin
        if (((i >> j) & 1) == 0) begin
          p   = i + (1 << j);
          a   = r[i*WIDTH +: WIDTH];
          b   = r[p*WIDTH +: WIDTH];
          asc = (((i >> k) & 1) == 0);
`ifdef SORT_DESC_EN
          asc = ~asc;
`endif
          if (asc ? (a > b) : (a < b)) begin
            r[i*WIDTH +: WIDTH] = b;
            r[p*WIDTH +: WIDTH] = a;
          end
        end
      end
    end
    return r;
  endfunction

  // Combinational merges. Each stage is fed by the register of the previous stage.
  always_comb begin
    s1_d = merge_stage(bus.in_data, 1);
    s2_d = merge_stage(s1_q, 2);
    s3_d = merge_stage(s2_q, 3);
  end

  // Pipeline registers. Reset clears every vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.s1_data = s1_q;
  assign bus.s2_data = s2_q;
  assign bus.s3_data = s3_q;

endmodule

// File: tb/tb_bitonic_stages_1to3.sv
// Self-checking bench for bitonic_stages_1to3 with INDEX=8 and WIDTH=5.
// The reference model sorts each aligned block directly, using the block's
// direction. It does not use any compare-exchange network.
module tb_bitonic_stages_1to3;
  localparam int INDEX = 8;
  localparam int WIDTH = 5;
  localparam int N     = INDEX * WIDTH;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [N-1:0] exp1_q[$];
  logic [N-1:0] exp2_q[$];
  logic [N-1:0] exp3_q[$];

  bitonic_stages_1to3_if #(.INDEX(INDEX), .WIDTH(WIDTH)) bus ();

  bitonic_stages_1to3 #(.INDEX(INDEX), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mk8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    int e[8];
    logic [N-1:0] v;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    v = '0;
    for (int i = 0; i < 8; i++) v[i*WIDTH +: WIDTH] = e[i][WIDTH-1:0];
    return v;
  endfunction

  // Reference: sort every aligned block of size bs, even blocks ascending
  // (inverted when SORT_DESC_EN is defined).
  function automatic logic [N-1:0] sort_blocks(input logic [N-1:0] v, input int bs);
    int e[INDEX];
    int t;
    bit up;
    logic [N-1:0] r;
    for (int i = 0; i < INDEX; i++) e[i] = int'(v[i*WIDTH +: WIDTH]);
    for (int b = 0; b < INDEX / bs; b++) begin
      up = (b % 2 == 0);
`ifdef SORT_DESC_EN
      up = !up;
`endif
      for (int p = 0; p < bs; p++) begin
        for (int q = b*bs; q < b*bs + bs - 1; q++) begin
          if (up ? (e[q] > e[q+1]) : (e[q] < e[q+1])) begin
            t = e[q]; e[q] = e[q+1]; e[q+1] = t;
          end
        end
      end
    end
    r = '0;
    for (int i = 0; i < INDEX; i++) r[i*WIDTH +: WIDTH] = e[i][WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < INDEX; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    return v;
  endfunction

  // Driver: applies one vector and rst value for one clock. It updates the
  // scoreboard queues, then checks every stage 1 time unit after the edge.
  // Reset flushes the vectors in flight, so their expected values become zero.
  task automatic cycle(input logic [N-1:0] v, input logic r);
    bus.in_data = v;
    rst         = r;
    if (r) begin
      foreach (exp1_q[i]) exp1_q[i] = '0;
      foreach (exp2_q[i]) exp2_q[i] = '0;
      foreach (exp3_q[i]) exp3_q[i] = '0;
      exp1_q.push_back('0);
      exp2_q.push_back('0);
      exp3_q.push_back('0);
    end else begin
      exp1_q.push_back(sort_blocks(v, 2));
      exp2_q.push_back(sort_blocks(v, 4));
      exp3_q.push_back(sort_blocks(v, 8));
    end
    @(posedge clk);
    #1;
    if (exp1_q.size() >= 1) check("s1_model", bus.s1_data, exp1_q.pop_front());
    if (exp2_q.size() >= 2) check("s2_model", bus.s2_data, exp2_q.pop_front());
    if (exp3_q.size() >= 3) check("s3_model", bus.s3_data, exp3_q.pop_front());
  endtask

  logic [N-1:0] perm_v, seq_v, dup_v, asc_v, pre_v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.in_data = '0;
    perm_v = mk8(7, 3, 5, 1, 6, 2, 4, 0);
    seq_v  = mk8(0, 1, 2, 3, 4, 5, 6, 7);
    dup_v  = mk8(31, 0, 31, 0, 5, 5, 0, 31);
`ifdef SORT_DESC_EN
    asc_v  = mk8(7, 6, 5, 4, 3, 2, 1, 0);
`else
    asc_v  = seq_v;
`endif

    // Reset for 2 cycles with random input.
    cycle(rand_vec(), 1'b1);
    cycle(rand_vec(), 1'b1);
    check("rst_s1", bus.s1_data, '0);
    check("rst_s2", bus.s2_data, '0);
    check("rst_s3", bus.s3_data, '0);

    // Permutation vector, followed back-to-back by the ordered vector.
    cycle(perm_v, 1'b0);
`ifdef SORT_DESC_EN
    check("perm_s1", bus.s1_data, mk8(7, 3, 1, 5, 6, 2, 0, 4));
`else
    check("perm_s1", bus.s1_data, mk8(3, 7, 5, 1, 2, 6, 4, 0));
`endif
    cycle(seq_v, 1'b0);
`ifndef SORT_DESC_EN
    check("perm_s2", bus.s2_data, mk8(1, 3, 5, 7, 6, 4, 2, 0));
`endif
    cycle(rand_vec(), 1'b0);
    check("perm_s3", bus.s3_data, asc_v);
    cycle(rand_vec(), 1'b0);
    check("b2b_s3", bus.s3_data, asc_v);

    // Duplicates and extreme values.
    cycle(dup_v, 1'b0);
    cycle(rand_vec(), 1'b0);
    cycle(rand_vec(), 1'b0);
`ifdef SORT_DESC_EN
    check("dup_s3", bus.s3_data, mk8(31, 31, 31, 5, 5, 0, 0, 0));
`else
    check("dup_s3", bus.s3_data, mk8(0, 0, 0, 5, 5, 31, 31, 31));
`endif

    // Reset one cycle after a vector enters. That vector must never reach s3.
    pre_v = mk8(9, 30, 17, 4, 22, 11, 1, 28);
    cycle(pre_v, 1'b0);
    cycle(rand_vec(), 1'b1);
    check("mid_rst_s1", bus.s1_data, '0);
    check("mid_rst_s2", bus.s2_data, '0);
    check("mid_rst_s3", bus.s3_data, '0);
    cycle(rand_vec(), 1'b0);
    check("refill_s3_a", bus.s3_data, '0);
    cycle(rand_vec(), 1'b0);
    check("refill_s3_b", bus.s3_data, '0);
    cycle(rand_vec(), 1'b0);

    // Random stream with occasional resets.
    for (int n = 0; n < 300; n++) begin
      cycle(rand_vec(), ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound, so the bench cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
